// File: rtl/nonce_tx_queue.sv
// rtl/nonce_tx_queue.sv - golden nonce FIFO feeding the serial word transmitter
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-low
//   golden_valid  one-cycle strobe, golden_nonce is valid
//   golden_nonce  32-bit nonce from the hashing core
//   load_flag     new-work indicator; every toggle flushes the queue
//   tx_busy       transmitter busy
//   tx_send       one-cycle registered send strobe
//   tx_word       word presented with tx_send, held until the next send
//   count         FIFO occupancy, 0..DEPTH
//   drop_cnt      nonces lost to a full FIFO, saturating at 255
module nonce_tx_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int GAP_CYCLES = 16,
  parameter bit DEDUP      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              golden_valid,
  input  logic [31:0]       golden_nonce,
  input  logic              load_flag,
  input  logic              tx_busy,
  output logic              tx_send,
  output logic [31:0]       tx_word,
  output logic [ADDR_W:0]   count,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              load_flag_q;
  logic [31:0]       last_nonce;
  logic              last_valid;
  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        hi_cnt;

  logic flush;
  logic full;
  logic dup;
  logic pop;
  logic push;
  logic overflow;

  always_comb begin
    flush    = load_flag ^ load_flag_q;
    full     = (count == DEPTH_C);
    dup      = DEDUP && last_valid && (golden_nonce == last_nonce);
    // Popping is the IDLE send decision; it is suppressed while flushing so a
    // stale head entry is never sent.
    pop      = (state == IDLE) && (count != '0) && !tx_busy && !flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = !flush && golden_valid && !dup && (!full || pop);
    overflow = !flush && golden_valid && !dup && full && !pop;
  end

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= golden_nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      load_flag_q <= 1'b0;
      last_nonce  <= '0;
      last_valid  <= 1'b0;
      state       <= IDLE;
      gap_cnt     <= '0;
      hi_cnt      <= '0;
      tx_send     <= 1'b0;
      tx_word     <= '0;
    end else begin
      load_flag_q <= load_flag;
      tx_send     <= 1'b0;

      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        last_valid <= 1'b0;
      end else begin
        if (push) begin
          wptr       <= wptr + ADDR_W'(1);
          last_nonce <= golden_nonce;
          last_valid <= 1'b1;
        end
        if (pop) begin
          rptr <= rptr + ADDR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (ADDR_W + 1)'(1);
          2'b01:   count <= count - (ADDR_W + 1)'(1);
          default: ;
        endcase
      end

      if (overflow && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      // The FSM is deliberately not touched by flush: a word already handed
      // to the transmitter still has to complete its busy/gap sequence.
      case (state)
        IDLE: begin
          if (pop) begin
            tx_send <= 1'b1;
            tx_word <= mem[rptr];
            hi_cnt  <= '0;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (hi_cnt == 2'd3) begin
            // Transmitter never acknowledged; give up on the word.
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            hi_cnt <= hi_cnt + 2'd1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_tx_queue.sv
// tb/tb_nonce_tx_queue.sv - self-checking bench for nonce_tx_queue
module tb_nonce_tx_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        golden_valid;
  logic [31:0] golden_nonce;
  logic        load_flag;
  logic        hold_busy;
  logic        model_busy;
  logic        tx_busy;
  logic        tx_send;
  logic [31:0] tx_word;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  logic        nd_busy;
  logic        nd_send;
  logic [31:0] nd_word;
  logic [3:0]  nd_count;
  logic [7:0]  nd_drop;

  assign tx_busy = hold_busy | model_busy;

  nonce_tx_queue #(.DEPTH(8), .ADDR_W(3), .GAP_CYCLES(16), .DEDUP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .golden_valid(golden_valid), .golden_nonce(golden_nonce),
    .load_flag(load_flag), .tx_busy(tx_busy), .tx_send(tx_send), .tx_word(tx_word),
    .count(count), .drop_cnt(drop_cnt)
  );

  nonce_tx_queue #(.DEPTH(8), .ADDR_W(3), .GAP_CYCLES(0), .DEDUP(1'b0)) u_nd (
    .clk(clk), .rst(rst), .golden_valid(golden_valid), .golden_nonce(golden_nonce),
    .load_flag(load_flag), .tx_busy(nd_busy), .tx_send(nd_send), .tx_word(nd_word),
    .count(nd_count), .drop_cnt(nd_drop)
  );

  typedef struct {
    logic [31:0] nonce;
    bit          accept;
    logic [3:0]  exp_count;
    logic [7:0]  exp_drop;
  } burst_t;

  typedef struct {
    logic [31:0] nonce;
    bit          accept;
  } dd_t;

  burst_t      burst [10];
  dd_t         dd_v [5];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sends = 0;
  int nd_sends = 0;
  int send_cyc = 0;
  int fall_cyc = 0;
  int pre = 0;
  int bl = 0;
  int pre_cfg = 1;
  int bl_cfg = 4;
  int t0;
  int n0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: outputs are observed at the falling edge, sends are scored
  // against the expected queue, and the transmitter model advances.
  task automatic tick();
    logic nb;
    @(negedge clk);
    cyc++;
    if (tx_send) begin
      sends++;
      send_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send actual=%0h expected=none", tx_word);
      end else begin
        check("tx_word_order", tx_word, exp_q.pop_front());
      end
    end
    if (nd_send) nd_sends++;
    if (tx_send) begin
      pre = pre_cfg;
      bl  = bl_cfg;
    end else if (pre > 0) begin
      pre--;
    end else if (bl > 0) begin
      bl--;
    end
    nb = (pre == 0) && (bl > 0);
    if (prev_busy && !(hold_busy | nb)) fall_cyc = cyc;
    prev_busy  = hold_busy | nb;
    model_busy = nb;
  endtask

  task automatic drive(input logic [31:0] v);
    golden_valid = 1'b1;
    golden_nonce = v;
    tick();
    golden_valid = 1'b0;
  endtask

  task automatic wait_send(input int bound);
    int start;
    int k;
    start = sends;
    k = 0;
    while (sends == start && k < bound) begin
      tick();
      k++;
    end
    check("wait_send", 32'(sends - start), 32'd1);
  endtask

  task automatic wait_empty(input int bound);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < bound) begin
      tick();
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      burst[i].nonce     = 32'(i + 1);
      burst[i].accept    = (i < 8);
      burst[i].exp_count = (i < 8) ? 4'(i + 1) : 4'd8;
      burst[i].exp_drop  = (i < 8) ? 8'd0 : 8'(i - 7);
    end
    dd_v[0] = '{32'h12345678, 1'b1};
    dd_v[1] = '{32'h12345678, 1'b0};
    dd_v[2] = '{32'h12345678, 1'b0};
    dd_v[3] = '{32'h9ABCDEF0, 1'b1};
    dd_v[4] = '{32'h12345678, 1'b1};

    rst = 1'b0;
    golden_valid = 1'b0;
    golden_nonce = '0;
    load_flag = 1'b0;
    hold_busy = 1'b0;
    model_busy = 1'b0;
    nd_busy = 1'b0;
    tick();
    tick();
    check("rst_tx_send", tx_send, 1'b0);
    check("rst_tx_word", tx_word, 32'h0);
    check("rst_count", count, 4'd0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    rst = 1'b1;
    tick();

    // Single nonce: latency, head-to-empty, and the post-busy gap.
    pre_cfg = 3;
    bl_cfg  = 40;
    t0 = cyc;
    exp_q.push_back(32'hDEADBEEF);
    drive(32'hDEADBEEF);
    tick();
    check("t1_latency", 32'(send_cyc), 32'(t0 + 2));
    check("t1_count_empty", count, 4'd0);
    repeat (10) tick();
    exp_q.push_back(32'h0BADF00D);
    drive(32'h0BADF00D);
    wait_send(100);
    // WAIT_LO->GAP edge, 17 GAP cycles, IDLE edge, registered send.
    check("t1_gap_spacing", 32'(send_cyc - fall_cyc), 32'd19);
    repeat (100) tick();

    // Burst into a held-off transmitter: saturate at DEPTH, count drops.
    pre_cfg = 1;
    bl_cfg  = 4;
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      golden_valid = 1'b1;
      golden_nonce = burst[i].nonce;
      if (burst[i].accept) exp_q.push_back(burst[i].nonce);
      tick();
      check("t2_count", count, burst[i].exp_count);
      check("t2_drop", drop_cnt, burst[i].exp_drop);
    end
    golden_valid = 1'b0;
    hold_busy = 1'b0;
    wait_empty(600);
    repeat (40) tick();

    // Repeated nonces: dedup instance sends 3, non-dedup instance sends 5.
    nd_sends = 0;
    for (int i = 0; i < 5; i++) begin
      golden_valid = 1'b1;
      golden_nonce = dd_v[i].nonce;
      if (dd_v[i].accept) exp_q.push_back(dd_v[i].nonce);
      tick();
    end
    golden_valid = 1'b0;
    wait_empty(400);
    repeat (40) tick();
    check("t3_nodedup_sends", 32'(nd_sends), 32'd5);
    check("t3_drop_kept", drop_cnt, 8'd2);

    // Flush with a coincident push: everything discarded, nothing sent.
    hold_busy = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) drive(32'h40 + 32'(k));
    check("t4_count_filled", count, 4'd5);
    n0 = sends;
    load_flag = ~load_flag;
    golden_valid = 1'b1;
    golden_nonce = 32'hCAFEF00D;
    tick();
    golden_valid = 1'b0;
    check("t4_count_flushed", count, 4'd0);
    check("t4_drop_kept", drop_cnt, 8'd2);
    hold_busy = 1'b0;
    repeat (40) tick();
    check("t4_no_send", 32'(sends - n0), 32'd0);

    // Full FIFO with a pop and a push in the same cycle.
    hold_busy = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'hA0 + 32'(k));
      drive(32'hA0 + 32'(k));
    end
    check("t5_count_full", count, 4'd8);
    hold_busy = 1'b0;
    golden_valid = 1'b1;
    golden_nonce = 32'hA8;
    exp_q.push_back(32'hA8);
    tick();
    golden_valid = 1'b0;
    hold_busy = 1'b1;
    check("t5_send", tx_send, 1'b1);
    check("t5_count_same", count, 4'd8);
    check("t5_drop_kept", drop_cnt, 8'd2);

    // Reset while waiting for busy to fall with entries queued.
    tick();
    load_flag = ~load_flag;
    exp_q.delete();
    tick();
    check("t6_count_flushed", count, 4'd0);
    for (int k = 0; k < 3; k++) drive(32'hB0 + 32'(k));
    check("t6_count_queued", count, 4'd3);
    n0 = sends;
    rst = 1'b0;
    tick();
    check("t6_rst_count", count, 4'd0);
    check("t6_rst_send", tx_send, 1'b0);
    check("t6_rst_drop", drop_cnt, 8'd0);
    rst = 1'b1;
    repeat (5) tick();
    hold_busy = 1'b0;
    repeat (3) tick();
    hold_busy = 1'b1;
    repeat (3) tick();
    hold_busy = 1'b0;
    repeat (20) tick();
    check("t6_no_send", 32'(sends - n0), 32'd0);
    t0 = cyc;
    exp_q.push_back(32'hC0FFEE11);
    drive(32'hC0FFEE11);
    tick();
    check("t6_idle_latency", 32'(send_cyc), 32'(t0 + 2));
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
